// File: rtl/md_pkg.sv
// Shared definitions for the mult/div issue arbiter: aluOp codes, FSM states
// and the request-slot record layout.
package md_pkg;

   localparam logic [4:0] ALU_MULT = 5'd6;
   localparam logic [4:0] ALU_DIV  = 5'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_WB
   } md_state_t;

   typedef struct packed {
      logic [4:0]  op;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [4:0]  rd;
   } md_slot_t;

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == ALU_MULT) || (op == ALU_DIV);
   endfunction

endpackage

// File: rtl/md_req_slot.sv
// One latched mult/div request (op, operands, destination). A fresh load wins
// over a forwarded operand write.
module md_req_slot
   import md_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [4:0]  load_op,
   input  logic [31:0] load_a,
   input  logic [31:0] load_b,
   input  logic [4:0]  load_rd,
   input  logic        fwd_a,
   input  logic        fwd_b,
   input  logic [31:0] fwd_data,
   output logic [4:0]  op,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic [4:0]  rd
);

   md_slot_t slot;

   always_ff @(posedge clock) begin
      if (reset) begin
         slot <= '0;
      end else if (load) begin
         slot.op   <= load_op;
         slot.op_a <= load_a;
         slot.op_b <= load_b;
         slot.rd   <= load_rd;
      end else begin
         if (fwd_a) slot.op_a <= fwd_data;
         if (fwd_b) slot.op_b <= fwd_data;
      end
   end

   assign op   = slot.op;
   assign op_a = slot.op_a;
   assign op_b = slot.op_b;
   assign rd   = slot.rd;

endmodule

// File: rtl/multdiv_issue_arbiter.sv
// Shares one multi-cycle mult/div unit between the two pipes, oldest first,
// stalling the front end and returning each result for writeback.
module multdiv_issue_arbiter
   import md_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        dx_req,
   input  logic [4:0]  dx_aluOp,
   input  logic [31:0] dx_opA,
   input  logic [31:0] dx_opB,
   input  logic [4:0]  dx_rd,
   input  logic        dx_req2,
   input  logic [4:0]  dx_aluOp2,
   input  logic [31:0] dx_opA2,
   input  logic [31:0] dx_opB2,
   input  logic [4:0]  dx_rd2,
   input  logic        dep2A,
   input  logic        dep2B,
   output logic        md_ctrlMult,
   output logic        md_ctrlDiv,
   output logic [31:0] md_opA,
   output logic [31:0] md_opB,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        md_stall,
   output logic        wb_valid,
   output logic        wb_pipe,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_exception
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   md_state_t        state, next_state;
   logic             pending;
   logic             active;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      cap_data;
   logic             cap_exc;

   logic        any_req, slot_load, fwd_en;
   logic [4:0]  s1_op, s2_op, s1_rd, s2_rd, act_op, act_rd;
   logic [31:0] s1_a, s1_b, s2_a, s2_b, act_a, act_b;

   assign any_req   = dx_req | dx_req2;
   assign slot_load = (state == ST_IDLE) && any_req;
   // Only a pipe-1 result can feed pipe 2, and only while pipe 2 still waits.
   assign fwd_en    = (state == ST_WB) && pending && !active;

   md_req_slot u_slot1 (
      .clock(clock), .reset(reset), .load(slot_load),
      .load_op(dx_aluOp), .load_a(dx_opA), .load_b(dx_opB), .load_rd(dx_rd),
      .fwd_a(1'b0), .fwd_b(1'b0), .fwd_data(32'd0),
      .op(s1_op), .op_a(s1_a), .op_b(s1_b), .rd(s1_rd)
   );

   md_req_slot u_slot2 (
      .clock(clock), .reset(reset), .load(slot_load),
      .load_op(dx_aluOp2), .load_a(dx_opA2), .load_b(dx_opB2), .load_rd(dx_rd2),
      .fwd_a(fwd_en && dep2A), .fwd_b(fwd_en && dep2B), .fwd_data(cap_data),
      .op(s2_op), .op_a(s2_a), .op_b(s2_b), .rd(s2_rd)
   );

   assign act_op = active ? s2_op : s1_op;
   assign act_a  = active ? s2_a  : s1_a;
   assign act_b  = active ? s2_b  : s1_b;
   assign act_rd = active ? s2_rd : s1_rd;

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (any_req) next_state = ST_ISSUE;
         ST_ISSUE: next_state = is_muldiv(act_op) ? ST_WAIT : ST_WB;
         ST_WAIT:  if (md_resultRDY || cnt == CNT_LAST) next_state = ST_WB;
         ST_WB:    next_state = pending ? ST_ISSUE : ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Slot selection, wait counter and result capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending  <= 1'b0;
         active   <= 1'b0;
         cnt      <= '0;
         cap_data <= '0;
         cap_exc  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  active  <= !dx_req;
                  pending <= dx_req && dx_req2;
               end
            end
            ST_ISSUE: begin
               cnt <= '0;
               if (!is_muldiv(act_op)) begin
                  cap_data <= '0;
                  cap_exc  <= 1'b0;
               end
            end
            ST_WAIT: begin
               cnt <= cnt + 1'b1;
               if (md_resultRDY) begin
                  cap_data <= md_result;
                  cap_exc  <= md_exception;
               end else if (cnt == CNT_LAST) begin
                  cap_data <= '0;
                  cap_exc  <= 1'b1;
               end
            end
            ST_WB: begin
               pending <= 1'b0;
               active  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      md_ctrlMult  = 1'b0;
      md_ctrlDiv   = 1'b0;
      md_opA       = '0;
      md_opB       = '0;
      md_stall     = 1'b0;
      wb_valid     = 1'b0;
      wb_pipe      = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      wb_exception = 1'b0;
      case (state)
         ST_IDLE: md_stall = any_req;
         ST_ISSUE: begin
            md_stall    = 1'b1;
            md_ctrlMult = (act_op == ALU_MULT);
            md_ctrlDiv  = (act_op == ALU_DIV);
            md_opA      = act_a;
            md_opB      = act_b;
         end
         ST_WAIT: begin
            md_stall = 1'b1;
            md_opA   = act_a;
            md_opB   = act_b;
         end
         ST_WB: begin
            // Stall drops in the last WB so DX advances as the FSM returns to IDLE.
            md_stall     = pending;
            wb_valid     = 1'b1;
            wb_pipe      = active;
            wb_rd        = act_rd;
            wb_data      = cap_data;
            wb_exception = cap_exc;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multdiv_issue_arbiter.sv
// Scoreboard bench for multdiv_issue_arbiter: directed requests, a behavioural
// mult/div unit, and a monitor checking issue pulses and writebacks.
module tb_multdiv_issue_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        dx_req, dx_req2, dep2A, dep2B;
   logic [4:0]  dx_aluOp, dx_rd, dx_aluOp2, dx_rd2;
   logic [31:0] dx_opA, dx_opB, dx_opA2, dx_opB2;
   logic        md_ctrlMult, md_ctrlDiv;
   logic [31:0] md_opA, md_opB;
   logic [31:0] md_result;
   logic        md_exception, md_resultRDY;
   logic        md_stall, wb_valid, wb_pipe, wb_exception;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic        mult;
      logic        div;
      logic [31:0] a;
      logic [31:0] b;
   } issue_t;

   typedef struct {
      logic        pipe;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        exc;
   } wb_t;

   issue_t iss_q[$];
   wb_t    wb_q[$];

   int unit_lat = 4;
   bit unit_norsp = 0;

   multdiv_issue_arbiter dut (
      .clock(clock), .reset(reset),
      .dx_req(dx_req), .dx_aluOp(dx_aluOp), .dx_opA(dx_opA), .dx_opB(dx_opB), .dx_rd(dx_rd),
      .dx_req2(dx_req2), .dx_aluOp2(dx_aluOp2), .dx_opA2(dx_opA2), .dx_opB2(dx_opB2), .dx_rd2(dx_rd2),
      .dep2A(dep2A), .dep2B(dep2B),
      .md_ctrlMult(md_ctrlMult), .md_ctrlDiv(md_ctrlDiv), .md_opA(md_opA), .md_opB(md_opB),
      .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
      .md_stall(md_stall), .wb_valid(wb_valid), .wb_pipe(wb_pipe), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_exception(wb_exception)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Behavioural mult/div unit: rdy arrives unit_lat cycles after the start pulse.
   initial begin
      int countdown;
      logic [31:0] res;
      logic        exc;
      countdown = 0;
      res = 0;
      exc = 0;
      md_result = 0;
      md_exception = 0;
      md_resultRDY = 0;
      forever begin
         @(negedge clock);
         md_resultRDY = 0;
         md_result = 0;
         md_exception = 0;
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
               md_resultRDY = 1;
               md_result = res;
               md_exception = exc;
            end
         end else if ((md_ctrlMult || md_ctrlDiv) && !unit_norsp) begin
            if (md_ctrlMult) begin
               res = md_opA * md_opB;
               exc = 0;
            end else if (md_opB == 0) begin
               res = 0;
               exc = 1;
            end else begin
               res = md_opA / md_opB;
               exc = 0;
            end
            countdown = unit_lat;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT starts the unit or writes back.
   initial begin
      issue_t ei;
      wb_t    ew;
      forever begin
         @(posedge clock);
         #1;
         if (md_ctrlMult || md_ctrlDiv) begin
            if (iss_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL issue_unexpected: got mult=%0b div=%0b a=%0d b=%0d expected none",
                        md_ctrlMult, md_ctrlDiv, md_opA, md_opB);
            end else begin
               ei = iss_q.pop_front();
               compared++;
               if (md_ctrlMult !== ei.mult || md_ctrlDiv !== ei.div || md_opA !== ei.a || md_opB !== ei.b) begin
                  mismatched++;
                  $display("[TB] FAIL issue: got mult=%0b div=%0b a=%0d b=%0d expected mult=%0b div=%0b a=%0d b=%0d",
                           md_ctrlMult, md_ctrlDiv, md_opA, md_opB, ei.mult, ei.div, ei.a, ei.b);
               end
            end
         end
         if (wb_valid) begin
            if (wb_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL wb_unexpected: got pipe=%0b rd=%0d data=%0d exc=%0b expected none",
                        wb_pipe, wb_rd, wb_data, wb_exception);
            end else begin
               ew = wb_q.pop_front();
               compared++;
               if (wb_pipe !== ew.pipe || wb_rd !== ew.rd || wb_data !== ew.data || wb_exception !== ew.exc) begin
                  mismatched++;
                  $display("[TB] FAIL wb: got pipe=%0b rd=%0d data=%0d exc=%0b expected pipe=%0b rd=%0d data=%0d exc=%0b",
                           wb_pipe, wb_rd, wb_data, wb_exception, ew.pipe, ew.rd, ew.data, ew.exc);
               end
            end
         end
      end
   end

   task automatic expectIssue(input logic mult, input logic div, input logic [31:0] a, input logic [31:0] b);
      issue_t e;
      e.mult = mult; e.div = div; e.a = a; e.b = b;
      iss_q.push_back(e);
   endtask

   task automatic expectWb(input logic pipe, input logic [4:0] rd, input logic [31:0] data, input logic exc);
      wb_t e;
      e.pipe = pipe; e.rd = rd; e.data = data; e.exc = exc;
      wb_q.push_back(e);
   endtask

   task automatic clearInputs();
      dx_req = 0; dx_aluOp = 0; dx_opA = 0; dx_opB = 0; dx_rd = 0;
      dx_req2 = 0; dx_aluOp2 = 0; dx_opA2 = 0; dx_opB2 = 0; dx_rd2 = 0;
      dep2A = 0; dep2B = 0;
   endtask

   // Holds both DX latches until md_stall drops, then lets DX advance.
   task automatic applyStimulus(
      input string name,
      input logic r1, input logic [4:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] rd1,
      input logic r2, input logic [4:0] op2, input logic [31:0] a2, input logic [31:0] b2, input logic [4:0] rd2,
      input logic da, input logic db, input int exp_stall);
      int n;
      @(negedge clock);
      dx_req = r1; dx_aluOp = op1; dx_opA = a1; dx_opB = b1; dx_rd = rd1;
      dx_req2 = r2; dx_aluOp2 = op2; dx_opA2 = a2; dx_opB2 = b2; dx_rd2 = rd2;
      dep2A = da; dep2B = db;
      #1;
      n = md_stall ? 1 : 0;
      while (md_stall && n < 200) begin
         @(negedge clock);
         if (md_stall) n++;
      end
      checkOutput({name, "_stall_cycles"}, n, exp_stall);
      clearInputs();
      repeat (2) @(negedge clock);
   endtask

   initial begin
      clearInputs();
      reset = 1;
      repeat (2) @(negedge clock);
      checkOutput("reset_stall", md_stall, 0);
      checkOutput("reset_wb_valid", wb_valid, 0);
      checkOutput("reset_opA", md_opA, 0);
      checkOutput("reset_start", {md_ctrlMult, md_ctrlDiv}, 0);
      reset = 0;

      $display("[TB] test 1: single mult");
      expectIssue(1, 0, 7, 6);
      expectWb(0, 3, 42, 0);
      applyStimulus("t1", 1, 6, 7, 6, 3, 0, 0, 0, 0, 0, 0, 0, 6);

      $display("[TB] test 2: dual mult then div");
      expectIssue(1, 0, 12, 11);
      expectIssue(0, 1, 100, 4);
      expectWb(0, 5, 132, 0);
      expectWb(1, 6, 25, 0);
      applyStimulus("t2", 1, 6, 12, 11, 5, 1, 7, 100, 4, 6, 0, 0, 12);

      $display("[TB] test 3: forward pipe-1 result into pipe-2 opA");
      expectIssue(1, 0, 3, 5);
      expectIssue(0, 1, 15, 5);
      expectWb(0, 4, 15, 0);
      expectWb(1, 9, 3, 0);
      applyStimulus("t3", 1, 6, 3, 5, 4, 1, 7, 0, 5, 9, 1, 0, 12);

      $display("[TB] test 4: unit timeout");
      unit_norsp = 1;
      expectIssue(1, 0, 2, 3);
      expectWb(0, 7, 0, 1);
      applyStimulus("t4", 1, 6, 2, 3, 7, 0, 0, 0, 0, 0, 0, 0, 66);
      unit_norsp = 0;
      checkOutput("t4_idle_stall", md_stall, 0);

      $display("[TB] test 5: reset during WAIT");
      unit_lat = 3;
      expectIssue(1, 0, 4, 5);
      @(negedge clock);
      dx_req = 1; dx_aluOp = 6; dx_opA = 4; dx_opB = 5; dx_rd = 9;
      repeat (3) @(negedge clock);
      reset = 1;
      clearInputs();
      @(negedge clock);
      reset = 0;
      checkOutput("t5_rdy_present", md_resultRDY, 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput("t5_stall", md_stall, 0);
         checkOutput("t5_wb_valid", wb_valid, 0);
         checkOutput("t5_opA", md_opA, 0);
         @(negedge clock);
      end
      unit_lat = 4;

      $display("[TB] test 6: divide by zero");
      expectIssue(0, 1, 9, 0);
      expectWb(0, 8, 0, 1);
      applyStimulus("t6", 1, 7, 9, 0, 8, 0, 0, 77, 0, 0, 1, 1, 6);

      $display("[TB] test 7: pipe-2 only, non mult/div op, rd 0");
      expectWb(1, 0, 0, 0);
      applyStimulus("t7", 0, 0, 11, 22, 0, 1, 0, 33, 44, 0, 0, 0, 2);

      repeat (4) @(negedge clock);
      checkOutput("issue_q_drained", iss_q.size(), 0);
      checkOutput("wb_q_drained", wb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
